// File: rtl/fft_sample_loader_if.sv
// openMSP430 peripheral bus bundle: the CPU drives the master side, register blocks take the slave side.
interface fft_sample_loader_if;
    logic [13:0] per_addr;
    logic [15:0] per_din;
    logic        per_en;
    logic [1:0]  per_we;
    logic [15:0] per_dout;

    modport master (output per_addr, per_din, per_en, per_we, input per_dout);
    modport slave  (input per_addr, per_din, per_en, per_we, output per_dout);
endinterface

// File: rtl/fft_sample_loader.sv
// Peripheral-bus frame buffer for the 16-point radix-4 FFT: collects 16 complex Q15 samples
// and presents them in stage-1 butterfly order with an arm/strobe handshake.
module fft_sample_loader #(
    parameter logic [13:0] BASE_ADDR = 14'h0A0,
    parameter int unsigned DW        = 16
) (
    input  logic                mclk,
    input  logic                puc_rst,
    fft_sample_loader_if.slave  bus,
    output logic [16*DW-1:0]    samp_r,
    output logic [16*DW-1:0]    samp_i,
    output logic                frame_valid,
    output logic                frame_start
);

    localparam int unsigned NSAMP = 16;
    localparam int unsigned PW    = 4;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_DATA_R = 2'd1;
    localparam logic [1:0] OFF_DATA_I = 2'd2;
    localparam logic [1:0] OFF_RD_IDX = 2'd3;

    typedef enum logic [1:0] {
        S_EMPTY   = 2'd0,
        S_FILLING = 2'd1,
        S_FULL    = 2'd2,
        S_RUN     = 2'd3
    } state_t;

    state_t          state;
    logic [DW-1:0]   buf_r [NSAMP];
    logic [DW-1:0]   buf_i [NSAMP];
    logic [DW-1:0]   staging_r;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_idx;
    logic            ovf;
    logic            err;

    // Address decode: unsigned wrap makes addresses below BASE_ADDR fall out of range too.
    logic [13:0] offset;
    logic        in_range;
    logic        wr_en;
    logic        rd_en;
    logic        wr_ctrl;
    logic        wr_data_r;
    logic        wr_data_i;
    logic        wr_rd_idx;
    logic        full;
    logic        run;

    assign offset    = bus.per_addr - BASE_ADDR;
    assign in_range  = (offset < 14'd4);
    assign wr_en     = bus.per_en && (bus.per_we == 2'b11) && in_range;
    assign rd_en     = bus.per_en && (bus.per_we == 2'b00) && in_range;
    assign wr_ctrl   = wr_en && (offset[1:0] == OFF_CTRL);
    assign wr_data_r = wr_en && (offset[1:0] == OFF_DATA_R);
    assign wr_data_i = wr_en && (offset[1:0] == OFF_DATA_I);
    assign wr_rd_idx = wr_en && (offset[1:0] == OFF_RD_IDX);

    assign full = (state == S_FULL) || (state == S_RUN);
    assign run  = (state == S_RUN);

    // Frame state, buffer and control registers.
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            state       <= S_EMPTY;
            staging_r   <= '0;
            wr_ptr      <= '0;
            rd_idx      <= '0;
            ovf         <= 1'b0;
            err         <= 1'b0;
            frame_valid <= 1'b0;
            frame_start <= 1'b0;
            for (int n = 0; n < NSAMP; n++) begin
                buf_r[n] <= '0;
                buf_i[n] <= '0;
            end
        end else begin
            frame_start <= 1'b0;

            // CLR takes priority over a START carried in the same write.
            if (wr_ctrl) begin
                if (bus.per_din[0]) begin
                    state       <= S_EMPTY;
                    wr_ptr      <= '0;
                    ovf         <= 1'b0;
                    err         <= 1'b0;
                    frame_valid <= 1'b0;
                end else if (bus.per_din[1]) begin
                    case (state)
                        S_FULL: begin
                            state       <= S_RUN;
                            frame_valid <= 1'b1;
                            frame_start <= 1'b1;
                        end
                        S_EMPTY, S_FILLING: err <= 1'b1;
                        default: ;
                    endcase
                end
            end

            if (wr_data_r) begin
                staging_r <= DW'(bus.per_din);
            end

            if (wr_data_i) begin
                if (full) begin
                    ovf <= 1'b1;
                end else begin
                    buf_r[wr_ptr] <= staging_r;
                    buf_i[wr_ptr] <= DW'(bus.per_din);
                    wr_ptr        <= PW'(wr_ptr + PW'(1));
                    state         <= (wr_ptr == PW'(NSAMP - 1)) ? S_FULL : S_FILLING;
                end
            end

            if (wr_rd_idx) begin
                rd_idx <= bus.per_din[PW-1:0];
            end
        end
    end

    // Combinational read-back; zero whenever this block is not being read.
    always_comb begin
        bus.per_dout = '0;
        if (rd_en) begin
            case (offset[1:0])
                OFF_CTRL:   bus.per_dout = {8'b0, wr_ptr, err, ovf, run, full};
                OFF_DATA_R: bus.per_dout = 16'(buf_r[rd_idx]);
                OFF_DATA_I: bus.per_dout = 16'(buf_i[rd_idx]);
                default:    bus.per_dout = {12'b0, rd_idx};
            endcase
        end
    end

    // Butterfly k, input j reads sample k+4j (stage-1 radix-4 ordering).
    for (genvar k = 0; k < 4; k++) begin : g_bfly
        for (genvar j = 0; j < 4; j++) begin : g_port
            assign samp_r[(4*k+j)*DW +: DW] = buf_r[k+4*j];
            assign samp_i[(4*k+j)*DW +: DW] = buf_i[k+4*j];
        end
    end

endmodule

// File: doc/fft_sample_loader.md
# fft_sample_loader

Peripheral-bus write-side front end for the 16-point radix-4 FFT core. The CPU writes 16 complex Q15 samples over the openMSP430 peripheral bus into a local frame buffer. The buffer presents them, already in stage-1 butterfly order, as parallel buses feeding the four butterfly input ports. A control/status register arms the frame, and a one-cycle strobe tells the FFT datapath that the inputs are stable.

## Interface
- BASE_ADDR, 14'h0A0, word address of register 0; the block decodes BASE_ADDR..BASE_ADDR+3.
- DW, 16, sample component width; fixed at 16 for this FFT.
- mclk  in  1  system clock.
- puc_rst  in  1  reset; asynchronous, active-high.
- per_addr  in  14  peripheral word address.
- per_din  in  16  write data.
- per_en  in  1  bus cycle enable.
- per_we  in  2  byte write enables; 2'b00 means read.
- per_dout  out  16  read data; 0 when not addressed.
- samp_r  out  256  real parts; butterfly k (0..3), input j (A..D = 0..3) at bits [(4k+j)*16 +: 16], carrying x_r[k+4j].
- samp_i  out  256  imaginary parts, same packing.
- frame_valid  out  1  high while a frozen frame is presented (RUN).
- frame_start  out  1  one-cycle strobe on entry to RUN.

## Operation
- Register map, offset from BASE_ADDR:
  - +0 CTRL. Write: bit0 CLR, bit1 START. Read: bit0 full, bit1 run, bit2 ovf (sticky), bit3 err (sticky), [7:4] wr_ptr, rest 0.
  - +1 DATA_R. Write: loads the staging real register. Read: x_r[rd_idx].
  - +2 DATA_I. Write: commits {staging_r, per_din} to x[wr_ptr], then wr_ptr++. Read: x_i[rd_idx].
  - +3 RD_IDX. Write: [3:0] sets rd_idx. Read: {12'b0, rd_idx}.
- Only full-word writes (per_we == 2'b11) take effect. Partial-byte writes are ignored entirely.
- States:
  - EMPTY: wr_ptr = 0, no samples.
  - FILLING: 1..15 samples committed.
  - FULL: 16 samples committed.
  - RUN: buffer frozen, frame_valid = 1.
- Transitions:
  - EMPTY → FILLING on the first commit.
  - FILLING → FULL on the commit at wr_ptr = 15. wr_ptr wraps to 0 and full = 1.
  - FULL → RUN on START.
  - Any state → EMPTY on CLR. CLR clears wr_ptr, full, run, ovf and err. Buffer contents are retained but will be overwritten.
- Boundary cases:
  - DATA_I write in FULL or RUN: ignored, sets ovf. Buffer and wr_ptr unchanged.
  - DATA_R write in RUN: staging register updates; buffer unaffected.
  - START in EMPTY or FILLING: ignored, sets err, no strobe.
  - START in RUN: no effect, no second strobe.
  - CLR and START in the same write: CLR wins and START is discarded.
- samp_r/samp_i are driven directly from buffer registers. They are valid in every state; consumers qualify them with frame_valid.
- No arithmetic is performed. Samples pass bit-exact as two's complement.

## Timing
- Reset (async assert, sync-safe release) clears:
  - all buffer entries, staging register, wr_ptr and rd_idx to 0;
  - state to EMPTY;
  - ovf, err, frame_valid and frame_start to 0;
  - per_dout to 0.
- Writes are sampled on the mclk rising edge in the cycle where per_en = 1. Register and state updates are visible the following cycle.
- A committed sample appears on samp_r/samp_i one cycle after the DATA_I bus cycle.
- frame_start and frame_valid both rise one cycle after the START bus cycle. frame_start falls after exactly one cycle.
- frame_valid falls one cycle after the CLR bus cycle.
- per_dout is combinational in the same cycle: per_en && per_we == 0 && address in range. Otherwise it is 0.
- Reset asserted mid-load or mid-RUN aborts immediately with no partial-frame strobe.

## Test plan
- Reset: assert puc_rst for 3 cycles, release → per_dout = 0, CTRL reads 0x0000, frame_valid = 0, all samp buses 0.
- Full load: write x_r[n] = n<<8 and x_i[n] = -n for n = 0..15 → CTRL reads 0x0001. samp_r[(4*1+2)*16 +: 16] = 0x0900, samp_i of the same slot = 0xFFF7. RD_IDX = 9 then DATA_I read returns 0xFFF7.
- Arm: write CTRL = 0x0002 after the full load → frame_start high for exactly 1 cycle, frame_valid stays high, CTRL reads 0x0003. A second START gives no second strobe.
- Overflow: commit a 17th DATA_I = 0x1234 while FULL → ovf set, CTRL reads 0x0005, x_i[0] unchanged at 0x0000.
- Premature START and byte writes:
  - 5 samples, then START → no strobe, CTRL reads 0x0058.
  - DATA_I write with per_we = 2'b01 → wr_ptr stays 5.
  - CTRL = 0x0003 (CLR + START together) → CTRL reads 0x0000, no strobe.
- Reset mid-operation: puc_rst pulsed after 7 commits, and again during RUN → all state zero on the next cycle, frame_valid drops. A subsequent 16-sample load and START behaves as in the Arm scenario.
